// File: rtl/ext_pipe_pkg.sv
// Shared definitions for the load/immediate extension pipeline.
// Mode encodings, legal widths and the alignment check live here.
package ext_pipe_pkg;

    localparam int DW32 = 32;
    localparam int DW64 = 64;

    typedef enum logic [2:0] {
        MODE_LB     = 3'd0,
        MODE_LBU    = 3'd1,
        MODE_LH     = 3'd2,
        MODE_LHU    = 3'd3,
        MODE_LW     = 3'd4,
        MODE_LUI    = 3'd5,
        MODE_SEXT16 = 3'd6,
        MODE_ZEXT16 = 3'd7
    } mode_e;

    typedef struct packed {
        mode_e      mode;
        logic [2:0] off;
        logic       err;
    } s1_ctrl_t;

    function automatic logic misaligned(input mode_e m, input logic [2:0] off);
        logic r;
        r = 1'b0;
        unique case (1'b1)
            (m == MODE_LH) || (m == MODE_LHU): r = off[0];
            (m == MODE_LW):                   r = |off[1:0];
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ext_lane.sv
// Combinational lane select and sign/zero fill between S1 and S2.
// Offsets are byte offsets; unused low bits are dropped per access size.
module ext_lane
    import ext_pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        off,
    input  mode_e             mode,
    output logic [DATA_W-1:0] res
);

    always_comb begin
        res = '0;
        unique case (mode)
            MODE_LB:     res = DATA_W'($signed(8'(data >> {off, 3'b000})));
            MODE_LBU:    res = DATA_W'(8'(data >> {off, 3'b000}));
            MODE_LH:     res = DATA_W'($signed(16'(data >> {off[2:1], 4'b0000})));
            MODE_LHU:    res = DATA_W'(16'(data >> {off[2:1], 4'b0000}));
            MODE_LW:     res = DATA_W'($signed(32'(data >> {off[2], 5'b00000})));
            MODE_LUI:    res = DATA_W'($signed({data[15:0], 16'h0000}));
            MODE_SEXT16: res = DATA_W'($signed(data[15:0]));
            MODE_ZEXT16: res = DATA_W'(data[15:0]);
            default:     res = '0;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Two-stage valid/ready load-extension pipeline (S1 capture, S2 result)
// with a saturating count of misaligned requests accepted.
module ext_pipe
    import ext_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [$clog2(DATA_W/8)-1:0]   in_off,
    input  logic [2:0]                    in_mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_err,
    output logic [CNT_W-1:0]              err_cnt
);

    if (!(DATA_W == DW32 || DATA_W == DW64)) begin : g_bad_width
        $error("ext_pipe: DATA_W must be 32 or 64");
    end

    logic              s1_valid;
    logic              s2_valid;
    logic              s1_adv;
    logic              s2_adv;
    logic              in_fire;
    s1_ctrl_t          in_ctrl;
    s1_ctrl_t          s1_ctrl;
    logic [DATA_W-1:0] s1_data;
    logic [DATA_W-1:0] lane_res;
    logic [DATA_W-1:0] s2_data;
    logic              s2_err;

    always_comb begin
        in_ctrl      = '0;
        in_ctrl.mode = mode_e'(in_mode);
        in_ctrl.off  = 3'(in_off);
        in_ctrl.err  = misaligned(mode_e'(in_mode), 3'(in_off));
    end

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = !rst && s1_adv;
    assign in_fire  = in_valid && in_ready;

    ext_lane #(
        .DATA_W (DATA_W)
    ) u_lane (
        .data (s1_data),
        .off  (s1_ctrl.off),
        .mode (s1_ctrl.mode),
        .res  (lane_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_ctrl  <= '0;
            s1_data  <= '0;
            s2_data  <= '0;
            s2_err   <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_ctrl <= in_ctrl;
                    s1_data <= in_data;
                end
            end
            // Bubbles leave the held result untouched.
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_ctrl.err ? '0 : lane_res;
                    s2_err  <= s1_ctrl.err;
                end
            end
            if (in_fire && in_ctrl.err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_err   = s2_err;

endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 Parameter DATA_W, default 32, meaning data path width; legal values 32 and 64 only.
REQ-002 Parameter CNT_W, default 8, meaning width of the saturating error counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 in_data  input  DATA_W  raw memory word or immediate source (immediate in bits [15:0]).
REQ-008 in_off  input  log2(DATA_W/8)  byte offset within in_data.
REQ-009 in_mode  input  3  operation select (REQ-014).
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_data  output  DATA_W  extended result.
REQ-013 out_err, output 1, misaligned request; err_cnt, output CNT_W, saturating count of misaligned requests accepted.

Function
REQ-014 Modes: 0 LB sign-ext byte; 1 LBU zero-ext byte; 2 LH sign-ext halfword; 3 LHU zero-ext halfword; 4 LW word (DATA_W=32: pass-through; DATA_W=64: sign-ext selected 32-bit word); 5 LUI in_data[15:0] placed at bits [31:16], bits [15:0] zero, sign-extended above bit 31 when DATA_W=64; 6 SEXT16 sign-ext in_data[15:0]; 7 ZEXT16 zero-ext in_data[15:0].
REQ-015 Byte lane for modes 0-4 SHALL be in_off (little-endian); halfword lane in_off[msb:1]; word lane in_off[msb:2].
REQ-016 Modes 5-7 SHALL ignore in_off and never flag error.
REQ-017 Misalignment: mode 2/3 with in_off[0]=1, or mode 4 with in_off[1:0]!=0, SHALL produce out_err=1 and out_data=0.
REQ-018 Pipeline SHALL have exactly two register stages (S1 capture, S2 result); latency in_valid&in_ready to out_valid = 2 cycles; throughput 1 per cycle with out_ready held high.
REQ-019 S2 advances when !s2_valid or out_ready; S1 advances when !s1_valid or S2 advances; in_ready equals the S1-advance condition, combinational from out_ready.
REQ-020 A transfer occurs only when valid and ready are both high on the same edge; while out_valid=1 and out_ready=0, out_data, out_err SHALL hold stable.
REQ-021 No request SHALL be dropped or duplicated under any out_ready pattern; order preserved.
REQ-022 err_cnt SHALL increment by 1 on the cycle a misaligned request is accepted at the input, saturating at 2^CNT_W-1; it does not wrap.
REQ-023 Simultaneous input accept and output consume with both stages full SHALL shift the pipeline with no bubble.

Reset
REQ-024 On rst=1 at a clock edge: s1/s2 valid=0, out_valid=0, out_data=0, out_err=0, err_cnt=0.
REQ-025 in_ready SHALL be 0 during rst=1 and 1 on the first cycle after rst deasserts.
REQ-026 Reset mid-operation SHALL discard all in-flight requests; no out_valid pulse follows for them.

Structure
REQ-027 Shared package SHALL hold mode encodings (MODE_LB..MODE_ZEXT16), legal DATA_W constants and the misalignment predicate function.
REQ-028 One combinational sub-module ext_lane (lane select + sign/zero fill, parameterised by DATA_W) SHALL sit between S1 and S2; registers stay in ext_pipe.
REQ-029 Elaboration SHALL fail for DATA_W not in {32, 64}.

Verification
REQ-030 DATA_W=32, mode 0, in_data=0x1234_80FF, in_off=1 -> 2 cycles later out_data=0xFFFF_FF80, out_err=0.
REQ-031 Mode 3, in_data=0x8001_7FFF, in_off=2 -> out_data=0x0000_8001; mode 2 same data -> 0xFFFF_8001.
REQ-032 Mode 4, in_off=2 -> out_err=1, out_data=0, err_cnt 0->1; 300 such requests with CNT_W=8 -> err_cnt=255.
REQ-033 Mode 5, in_data=0x0000_ABCD, DATA_W=64 -> out_data=0xFFFF_FFFF_ABCD_0000; mode 7 -> 0x0000_0000_0000_ABCD.
REQ-034 Back-to-back 16 requests, out_ready random 50% -> all 16 results in order, stable while stalled, in_ready=0 only when both stages full and out_ready=0.
REQ-035 rst asserted with both stages full -> next cycle out_valid=0, err_cnt=0, in_ready=0; after release no stale result emerges.
